// File: rtl/rot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rot_pkg                                                      |
// | Description : Shared types and constants for the rotator datapath.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rot_pkg;

  localparam int ROT_WIDTH = 8;

  typedef logic [ROT_WIDTH-1:0] rot_word_t;

  localparam logic SEL_LEFT  = 1'b1;
  localparam logic SEL_RIGHT = 1'b0;

endpackage : rot_pkg
`default_nettype wire

// File: rtl/mux_2to1_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_2to1_core                                                |
// | Description : Combinational 2:1 word selector (lr=1 picks left).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mux_2to1_core
  import rot_pkg::*;
#(
  parameter int WIDTH = ROT_WIDTH
) (
  input  logic [WIDTH-1:0] i_left,
  input  logic [WIDTH-1:0] i_right,
  input  logic             i_lr,
  output logic [WIDTH-1:0] o_sel
);

  assign o_sel = (i_lr == SEL_LEFT) ? i_left : i_right;

endmodule : mux_2to1_core
`default_nettype wire

// File: rtl/mux_2to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_2to1                                                     |
// | Description : Registered 2:1 word selector with a valid flag, 1-cycle lat. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mux_2to1
  import rot_pkg::*;
#(
  parameter int               WIDTH     = ROT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             lr,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_y;
  logic             r_out_valid;

  mux_2to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_left  (left),
    .i_right (right),
    .i_lr    (lr),
    .o_sel   (w_sel)
  );

  // y holds across idle cycles; only the valid flag drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y         <= RST_VALUE;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_y         <= w_sel;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign y         = r_y;
  assign out_valid = r_out_valid;

  a_lr_known : assert property (@(posedge clk) disable iff (rst)
                                in_valid |-> !$isunknown(lr));

endmodule : mux_2to1
`default_nettype wire

// File: tb/tb_mux_2to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mux_2to1                                                  |
// | Description : Directed self-checking bench for mux_2to1 (8 and 16 bit).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mux_2to1;

  logic        clk = 1'b0;
  logic        rst;
  logic        lr;
  logic        in_valid;
  logic [7:0]  left, right, y;
  logic [15:0] left16, right16, y16;
  logic        out_valid, out_valid16;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] RST16 = 16'hBEEF;

  always #5 clk = ~clk;

  mux_2to1 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .lr(lr),
    .in_valid(in_valid), .y(y), .out_valid(out_valid)
  );

  mux_2to1 #(.WIDTH(16), .RST_VALUE(RST16)) dut16 (
    .clk(clk), .rst(rst), .left(left16), .right(right16), .lr(lr),
    .in_valid(in_valid), .y(y16), .out_valid(out_valid16)
  );

  // Inputs change 1ns after an edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; lr = 1'b0;
    left = 8'h00; right = 8'h00; left16 = 16'h0000; right16 = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (y !== 8'h00 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_cycle%0d: y=%h out_valid=%b, want y=00 out_valid=0", i, y, out_valid);
      end
      checks++;
      if (y16 !== RST16 || out_valid16 !== 1'b0) begin
        errors++;
        $display("FAIL reset16_cycle%0d: y=%h out_valid=%b, want y=%h out_valid=0", i, y16, out_valid16, RST16);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (y !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: y=%h out_valid=%b, want y=00 out_valid=0", y, out_valid);
    end
  endtask

  task automatic test_select_right();
    left = 8'h00; right = 8'h01; lr = 1'b0; in_valid = 1'b1;
    tick();
    checks++;
    if (y !== 8'h01 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL select_right: y=%h out_valid=%b, want y=01 out_valid=1", y, out_valid);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp;
    lr = 1'b1;
    tick();
    checks++;
    if (y !== 8'h00 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL select_left: y=%h out_valid=%b, want y=00 out_valid=1", y, out_valid);
    end
    left = 8'hA5; right = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      lr  = (i % 2 == 0);
      exp = (i % 2 == 0) ? 8'hA5 : 8'h5A;
      tick();
      checks++;
      if (y !== exp || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL alternate_%0d: y=%h out_valid=%b, want y=%h out_valid=1", i, y, out_valid, exp);
      end
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b0; left = 8'h11; right = 8'h22; lr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (y !== 8'h5A || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: y=%h out_valid=%b, want y=5A out_valid=0", i, y, out_valid);
      end
      lr = 1'b0;
    end
  endtask

  task automatic test_left_eq_right();
    in_valid = 1'b1; left = 8'h3C; right = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      lr = i[0];
      tick();
      checks++;
      if (y !== 8'h3C || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL left_eq_right_lr%0d: y=%h out_valid=%b, want y=3C out_valid=1", i, y, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lv [4] = '{8'h12, 8'h80, 8'hC3, 8'h07};
    logic [7:0] rv [4] = '{8'h34, 8'h01, 8'h3C, 8'hF0};
    logic       sv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] ev [4] = '{8'h12, 8'h01, 8'h3C, 8'h07};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      left = lv[i]; right = rv[i]; lr = sv[i];
      tick();
      checks++;
      if (y !== ev[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back_%0d: y=%h out_valid=%b, want y=%h out_valid=1", i, y, out_valid, ev[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    left = 8'hFF; right = 8'h00; lr = 1'b1; in_valid = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (y !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: y=%h out_valid=%b, want y=00 out_valid=0", y, out_valid);
    end
    checks++;
    if (y16 !== RST16 || out_valid16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority16: y=%h out_valid=%b, want y=%h out_valid=0", y16, out_valid16, RST16);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (y !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: y=%h out_valid=%b, want y=00 out_valid=0", y, out_valid);
    end
  endtask

  task automatic test_wide();
    in_valid = 1'b1; left16 = 16'hFFFF; right16 = 16'h0000; lr = 1'b1;
    tick();
    checks++;
    if (y16 !== 16'hFFFF || out_valid16 !== 1'b1) begin
      errors++;
      $display("FAIL wide_left_ones: y=%h out_valid=%b, want y=FFFF out_valid=1", y16, out_valid16);
    end
    lr = 1'b0;
    tick();
    checks++;
    if (y16 !== 16'h0000 || out_valid16 !== 1'b1) begin
      errors++;
      $display("FAIL wide_right_zeros: y=%h out_valid=%b, want y=0000 out_valid=1", y16, out_valid16);
    end
    left16 = 16'h8001; right16 = 16'h7FFE; lr = 1'b1;
    tick();
    checks++;
    if (y16 !== 16'h8001) begin
      errors++;
      $display("FAIL wide_edge_bits_left: y=%h, want y=8001", y16);
    end
    lr = 1'b0;
    tick();
    checks++;
    if (y16 !== 16'h7FFE) begin
      errors++;
      $display("FAIL wide_edge_bits_right: y=%h, want y=7FFE", y16);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (y16 !== 16'h7FFE || out_valid16 !== 1'b0) begin
      errors++;
      $display("FAIL wide_hold: y=%h out_valid=%b, want y=7FFE out_valid=0", y16, out_valid16);
    end
  endtask

  initial begin
    test_reset();
    test_select_right();
    test_alternate();
    test_hold();
    test_left_eq_right();
    test_back_to_back();
    test_reset_priority();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, want completion before 100000");
    $fatal(1);
  end

endmodule : tb_mux_2to1
`default_nettype wire
